free_list_2a2r: RTL and testbench

FREE_LIST_2A2R -- requirements
Module: free_list_2a2r

---
 rtl/free_list_2a2r.sv | 136 +++++++++++++
 tb/tb_free_list_2a2r.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_2a2r.sv
// ----------------------------------------------------------------------------
// free_list_2a2r
//
// Free list of physical register tags with two allocate ports and two release
// ports. Tags sit in a circular buffer. Allocation reads from the head and
// release writes at the tail. Tags are presented show-ahead, so the consumer
// sees the next tags before it asks for them.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : asynchronous reset, active low
//   alloc1_req_i  : dispatch slot 1 wants a tag
//   alloc2_req_i  : dispatch slot 2 wants a tag
//   alloc1_tag_o  : tag for slot 1 (entry[head])
//   alloc2_tag_o  : tag for slot 2 (entry[head+1] when slot 1 also asks)
//   alloc_grant_o : all requested tags are valid this cycle (all-or-nothing)
//   free1_en_i    : commit releases free1_tag_i
//   free2_en_i    : commit releases free2_tag_i
//   free1_tag_i   : first released tag
//   free2_tag_i   : second released tag
//   free_count_o  : number of free tags held (registered)
//   empty_o       : no free tags held
//   err_o         : sticky overflow flag, cleared only by reset
// ----------------------------------------------------------------------------
module free_list_2a2r #(
  parameter int ARRAY_ENTRY   = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int NUM_ARCH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc1_req_i,
  input  logic                     alloc2_req_i,
  output logic [REGNAME_WIDTH-1:0] alloc1_tag_o,
  output logic [REGNAME_WIDTH-1:0] alloc2_tag_o,
  output logic                     alloc_grant_o,
  input  logic                     free1_en_i,
  input  logic                     free2_en_i,
  input  logic [REGNAME_WIDTH-1:0] free1_tag_i,
  input  logic [REGNAME_WIDTH-1:0] free2_tag_i,
  output logic [REGNAME_WIDTH:0]   free_count_o,
  output logic                     empty_o,
  output logic                     err_o
);

  localparam int INIT_FREE = ARRAY_ENTRY - NUM_ARCH;

  typedef logic [REGNAME_WIDTH-1:0] entry_arr_t [ARRAY_ENTRY];

  // Reset image: the tags not mapped architecturally, in ascending order.
  function automatic entry_arr_t reset_image();
    entry_arr_t img;
    for (int k = 0; k < ARRAY_ENTRY; k++) begin
      img[k] = (k < INIT_FREE) ? REGNAME_WIDTH'(NUM_ARCH + k) : '0;
    end
    return img;
  endfunction

  entry_arr_t                 entry_q, entry_d;
  logic [REGNAME_WIDTH-1:0]   head_q, head_d;
  logic [REGNAME_WIDTH-1:0]   tail_q, tail_d;
  logic [REGNAME_WIDTH:0]     count_q, count_d;
  logic                       err_q, err_d;

  logic [1:0]                 req_n;
  logic [1:0]                 free_n;
  logic [1:0]                 granted_n;
  logic                       grant;
  logic [REGNAME_WIDTH+1:0]   net_count;
  logic                       overflow;
  logic [REGNAME_WIDTH-1:0]   head_p1;
  logic [REGNAME_WIDTH-1:0]   tail_p1;

  always_comb begin
    req_n     = {1'b0, alloc1_req_i} + {1'b0, alloc2_req_i};
    free_n    = {1'b0, free1_en_i} + {1'b0, free2_en_i};
    head_p1   = head_q + REGNAME_WIDTH'(1);
    tail_p1   = tail_q + REGNAME_WIDTH'(1);

    // Grant looks only at the registered count, so tags released this cycle
    // cannot be handed out until the next one.
    grant     = (req_n != 2'd0) && (count_q >= (REGNAME_WIDTH+1)'(req_n));
    granted_n = grant ? req_n : 2'd0;

    // The fill check uses the net effect of both sides, since a slot being
    // read this cycle may be rewritten at the same edge.
    net_count = (REGNAME_WIDTH+2)'(count_q) - (REGNAME_WIDTH+2)'(granted_n)
              + (REGNAME_WIDTH+2)'(free_n);
    overflow  = (free_n != 2'd0) && (net_count > (REGNAME_WIDTH+2)'(ARRAY_ENTRY));

    entry_d = entry_q;
    head_d  = grant ? head_q + REGNAME_WIDTH'(granted_n) : head_q;
    tail_d  = tail_q;
    count_d = count_q - (REGNAME_WIDTH+1)'(granted_n);
    err_d   = err_q | overflow;

    // An overflowing release is dropped whole; the grant side still proceeds.
    if (!overflow) begin
      count_d = net_count[REGNAME_WIDTH:0];
      tail_d  = tail_q + REGNAME_WIDTH'(free_n);
      if (free1_en_i && free2_en_i) begin
        entry_d[tail_q]  = free1_tag_i;
        entry_d[tail_p1] = free2_tag_i;
      end else if (free1_en_i) begin
        entry_d[tail_q]  = free1_tag_i;
      end else if (free2_en_i) begin
        entry_d[tail_q]  = free2_tag_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= reset_image();
      head_q  <= '0;
      tail_q  <= REGNAME_WIDTH'(INIT_FREE);
      count_q <= (REGNAME_WIDTH+1)'(INIT_FREE);
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Show-ahead tag outputs; consumers qualify them with alloc_grant_o.
  assign alloc1_tag_o  = entry_q[head_q];
  assign alloc2_tag_o  = alloc1_req_i ? entry_q[head_p1] : entry_q[head_q];
  assign alloc_grant_o = grant;
  assign free_count_o  = count_q;
  assign empty_o       = (count_q == '0);
  assign err_o         = err_q;

endmodule

// File: tb/tb_free_list_2a2r.sv
// ----------------------------------------------------------------------------
// tb_free_list_2a2r
//
// Directed bench for free_list_2a2r. A queue model holds the free tags in
// allocation order; a compare process checks every cycle against it, and the
// directed sequence adds hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_free_list_2a2r;

  localparam int AE = 32;
  localparam int W  = 5;
  localparam int NA = 16;

  logic         clk;
  logic         rst;
  logic         alloc1_req_i, alloc2_req_i;
  logic [W-1:0] alloc1_tag_o, alloc2_tag_o;
  logic         alloc_grant_o;
  logic         free1_en_i, free2_en_i;
  logic [W-1:0] free1_tag_i, free2_tag_i;
  logic [W:0]   free_count_o;
  logic         empty_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  free_list_2a2r #(
    .ARRAY_ENTRY  (AE),
    .REGNAME_WIDTH(W),
    .NUM_ARCH     (NA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc1_req_i (alloc1_req_i),
    .alloc2_req_i (alloc2_req_i),
    .alloc1_tag_o (alloc1_tag_o),
    .alloc2_tag_o (alloc2_tag_o),
    .alloc_grant_o(alloc_grant_o),
    .free1_en_i   (free1_en_i),
    .free2_en_i   (free2_en_i),
    .free1_tag_i  (free1_tag_i),
    .free2_tag_i  (free2_tag_i),
    .free_count_o (free_count_o),
    .empty_o      (empty_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the free tags in the order they will be handed out, plus the
  // sticky error flag.
  int model_q[$];
  bit model_err;

  task automatic model_reset();
    model_q.delete();
    for (int k = NA; k < AE; k++) model_q.push_back(k);
    model_err = 1'b0;
  endtask

  // Model update at each edge: pop granted tags, then append released tags
  // unless the resulting population would exceed the capacity.
  always @(posedge clk or negedge rst) begin : model_update
    int  req_n;
    int  free_n;
    int  granted;
    if (!rst) begin
      model_reset();
    end else begin
      req_n   = int'(alloc1_req_i) + int'(alloc2_req_i);
      free_n  = int'(free1_en_i) + int'(free2_en_i);
      granted = (req_n > 0 && model_q.size() >= req_n) ? req_n : 0;
      for (int i = 0; i < granted; i++) void'(model_q.pop_front());
      if (free_n > 0 && model_q.size() + free_n > AE) begin
        model_err = 1'b1;
      end else begin
        if (free1_en_i) model_q.push_back(int'(free1_tag_i));
        if (free2_en_i) model_q.push_back(int'(free2_tag_i));
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    int req_n;
    int exp_grant;
    if (rst) begin
      req_n     = int'(alloc1_req_i) + int'(alloc2_req_i);
      exp_grant = (req_n > 0 && model_q.size() >= req_n) ? 1 : 0;
      checkOutput("model_grant", int'(alloc_grant_o), exp_grant);
      checkOutput("model_count", int'(free_count_o), model_q.size());
      checkOutput("model_empty", int'(empty_o), (model_q.size() == 0) ? 1 : 0);
      checkOutput("model_err", int'(err_o), int'(model_err));
      if (model_q.size() >= 1)
        checkOutput("model_tag1", int'(alloc1_tag_o), model_q[0]);
      if (alloc1_req_i && model_q.size() >= 2)
        checkOutput("model_tag2", int'(alloc2_tag_o), model_q[1]);
      else if (!alloc1_req_i && model_q.size() >= 1)
        checkOutput("model_tag2", int'(alloc2_tag_o), model_q[0]);
    end
  end

  // Drive one cycle of inputs just after the next rising edge.
  task automatic applyStimulus(input bit a1, input bit a2, input bit f1, input bit f2,
                               input int t1, input int t2);
    @(posedge clk);
    #1;
    alloc1_req_i = a1;
    alloc2_req_i = a2;
    free1_en_i   = f1;
    free2_en_i   = f2;
    free1_tag_i  = W'(t1);
    free2_tag_i  = W'(t2);
  endtask

  task automatic idleInputs();
    alloc1_req_i = 1'b0;
    alloc2_req_i = 1'b0;
    free1_en_i   = 1'b0;
    free2_en_i   = 1'b0;
    free1_tag_i  = '0;
    free2_tag_i  = '0;
  endtask

  // Reset asserted mid-cycle across one rising edge, inputs cleared before release.
  task automatic pulseReset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idleInputs();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    checkOutput("reset_count", int'(free_count_o), 16);
    checkOutput("reset_empty", int'(empty_o), 0);
    checkOutput("reset_err", int'(err_o), 0);
    checkOutput("reset_head_tag", int'(alloc1_tag_o), 16);

    // Dual allocate straight after reset.
    applyStimulus(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("dual_grant", int'(alloc_grant_o), 1);
    checkOutput("dual_tag1", int'(alloc1_tag_o), 16);
    checkOutput("dual_tag2", int'(alloc2_tag_o), 17);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("dual_count", int'(free_count_o), 14);

    // Reset during an active dual request; slot 2 alone then gets tag 16.
    applyStimulus(1, 1, 0, 0, 0, 0);
    pulseReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("slot2_grant", int'(alloc_grant_o), 1);
    checkOutput("slot2_tag", int'(alloc2_tag_o), 16);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("slot2_count", int'(free_count_o), 15);
    checkOutput("slot2_next_tag", int'(alloc1_tag_o), 17);

    // Drain to one tag, then dual is denied and single gets the last tag.
    pulseReset();
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("one_left_count", int'(free_count_o), 1);
    checkOutput("one_left_dual_deny", int'(alloc_grant_o), 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("last_grant", int'(alloc_grant_o), 1);
    checkOutput("last_tag", int'(alloc1_tag_o), 31);
    applyStimulus(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("empty_flag", int'(empty_o), 1);
    checkOutput("empty_dual_deny", int'(alloc_grant_o), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("empty_no_err", int'(err_o), 0);
    checkOutput("empty_count", int'(free_count_o), 0);

    // Release tags 1..15 so the tail reaches the last entry; head stayed put.
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 1, 2 * i + 1, 2 * i + 2);
    applyStimulus(0, 0, 1, 0, 15, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("refill_count", int'(free_count_o), 15);
    checkOutput("refill_head_tag", int'(alloc1_tag_o), 1);

    // Allocate 13, leaving tags 14 and 15; then dual alloc with dual free 3,5.
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 3, 5);
    @(negedge clk);
    checkOutput("swap_grant", int'(alloc_grant_o), 1);
    checkOutput("swap_tag1", int'(alloc1_tag_o), 14);
    checkOutput("swap_tag2", int'(alloc2_tag_o), 15);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("swap_count", int'(free_count_o), 2);
    applyStimulus(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wrap_tag1", int'(alloc1_tag_o), 3);
    checkOutput("wrap_tag2", int'(alloc2_tag_o), 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wrap_count", int'(free_count_o), 0);

    // Fill to capacity, then an extra release is dropped and flags an error.
    pulseReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 1, 2 * i, 2 * i + 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_count", int'(free_count_o), 32);
    checkOutput("full_err", int'(err_o), 0);
    applyStimulus(0, 0, 1, 0, 7, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("overflow_count", int'(free_count_o), 32);
    checkOutput("overflow_err", int'(err_o), 1);
    checkOutput("overflow_head_tag", int'(alloc1_tag_o), 16);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("overflow_err_sticky", int'(err_o), 1);
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_clears_err", int'(err_o), 0);
    checkOutput("reset_restores_count", int'(free_count_o), 16);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
